svi_lane_checker: RTL and testbench
===================================

# svi_lane_checker

Self-checking receiver for the 8-lane SVI-array stimulus bundle (`o_a`/`o_b`/`o_c`). It sits in the interface-array regression harness on the consuming side of a lane-array generator. It samples the three 8-bit lane buses under a valid strobe and compares each lane against a parameterised expected pattern. Over a fixed sample window it accumulates per-lane sticky error flags and a saturating mismatch count, then reports pass or fail.

## Interface
Parameters:
- `LANES`, 8: number of lanes; each bus is `LANES` bits wide, and lane k is bit k of every bus.
- `EXP_A`, 8'hFF: expected value on `i_a`.
- `EXP_B`, 8'h00: expected value on `i_b`.
- `EXP_C`, 8'hFF: expected value on `i_c`.
- `NSAMPLES`, 16: samples per check window; must be ≥1.
- `CNT_W`, 16: width of the mismatch counter.

Ports:
- `i_clk`, in, 1: clock. All logic is on the rising edge.
- `i_rst_n`, in, 1: reset, synchronous, active-low.
- `i_start`, in, 1: arm a new check window. Ignored unless in IDLE or DONE.
- `i_valid`, in, 1: the lane buses carry a sample this cycle.
- `i_a`, in, LANES: lane bus A.
- `i_b`, in, LANES: lane bus B.
- `i_c`, in, LANES: lane bus C.
- `o_busy`, out, 1: high in CHECK or DRAIN.
- `o_done`, out, 1: high in DONE. Results are final while it is high.
- `o_pass`, out, 1: high in DONE when `o_err_lanes` is all zero.
- `o_err_lanes`, out, LANES: sticky per-lane mismatch flags.
- `o_err_cnt`, out, CNT_W: count of samples with at least one mismatching lane; saturates at all-ones.
- `o_sample_cnt`, out, clog2(NSAMPLES+1): number of samples accepted in the current window.

## Operation
- FSM has four states: IDLE, CHECK, DRAIN, DONE.
  - IDLE to CHECK on `i_start`.
  - CHECK to DRAIN on the cycle after the NSAMPLES-th sample is accepted.
  - DRAIN to DONE after one cycle.
  - DONE to CHECK on `i_start`.
- Entering CHECK clears `o_err_lanes`, `o_err_cnt`, `o_sample_cnt` and the pipeline valid bit.
- A sample is accepted when the state is CHECK, `i_valid`=1 and `o_sample_cnt` < NSAMPLES. Accepting a sample increments `o_sample_cnt`.
- `i_valid` outside CHECK is ignored. Gaps in `i_valid` are allowed.
- The datapath is a two-stage pipeline:
  - Stage 1 registers `i_a`/`i_b`/`i_c` and a stage valid bit.
  - Stage 2 computes `mm[k] = (a[k]^EXP_A[k]) | (b[k]^EXP_B[k]) | (c[k]^EXP_C[k])`. When the stage is valid, it updates `o_err_lanes |= mm` and increments `o_err_cnt` by 1 if `|mm`.
- `o_err_cnt` saturates at 2^CNT_W−1 and never wraps.
- `i_start` asserted while in CHECK or DRAIN has no effect.
- `o_pass` is registered and is valid only while `o_done`=1; it is 0 in every other state.

## Timing
- Reset (`i_rst_n`=0 at a clock edge) puts the FSM in IDLE and sets every output to 0, including the pipeline valid bit. This applies in any state, including mid-window, and partial results are discarded.
- A sample accepted at edge t is reflected in `o_err_lanes`/`o_err_cnt` from cycle t+2.
- `o_sample_cnt` updates at t+1.
- If the last sample is accepted at t, the FSM is in DRAIN at t+1 and in DONE at t+2. `o_done`=1 and `o_pass`/flags are final from t+2.
- `o_busy` rises the cycle after `i_start` is sampled in IDLE/DONE. It falls in the same cycle `o_done` rises.
- The clear on re-start takes effect at the edge that enters CHECK. A sample with `i_valid` high in that same cycle is not accepted; acceptance begins the following cycle.

## Test plan
- Reset: hold `i_rst_n`=0 for 2 cycles with random inputs → all outputs 0, FSM in IDLE. A later `i_valid` without `i_start` leaves `o_sample_cnt`=0.
- Clean window: `i_start`, then 16 valid samples of a=FF, b=00, c=FF (default parameters) → `o_done`=1 two cycles after the last sample, `o_pass`=1, `o_err_lanes`=00, `o_err_cnt`=0, `o_sample_cnt`=16.
- Single-lane fault with gaps: drive 16 samples with `i_valid` toggling every other cycle. Samples 3 and 9 carry b=8'h20 → `o_err_lanes`=8'h20, `o_err_cnt`=2, `o_pass`=0. The 17th `i_valid` is ignored.
- Saturation: with CNT_W=3 and NSAMPLES=10, drive all samples with a=00 → `o_err_cnt`=7 (no wrap), `o_err_lanes`=FF.
- Start during CHECK and reset mid-window:
  - `i_start` pulsed after 5 samples → `o_sample_cnt` continues to 6, 7, … without clearing.
  - `i_rst_n`=0 after 8 samples → outputs return to 0 next cycle.
  - A new window then passes normally.
- Back-to-back windows: a failing window, then `i_start` in DONE → flags and counts clear on entry to CHECK, and a second clean window ends with `o_pass`=1.

Source files
------------

// File: rtl/svi_lane_checker.sv
// svi_lane_checker: receiver-side checker for an N-lane A/B/C lane bundle.
// Samples the three lane buses under i_valid, compares each lane against
// fixed expected bits, and accumulates sticky per-lane error flags and a
// saturating mismatch count over an NSAMPLES window, then reports pass/fail.

// Per-lane compare and sticky error flag.
module svi_lane_cmp #(
  parameter logic EXP_A_BIT = 1'b1,
  parameter logic EXP_B_BIT = 1'b0,
  parameter logic EXP_C_BIT = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_vld,
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_mm,
  output logic o_err
);
  logic err_q, err_d;

  // Lane mismatch is any of the three bits differing from its expected value.
  always_comb begin
    o_mm  = (i_a ^ EXP_A_BIT) | (i_b ^ EXP_B_BIT) | (i_c ^ EXP_C_BIT);
    err_d = err_q;
    if (i_clr)              err_d = 1'b0;
    else if (i_vld && o_mm) err_d = 1'b1;
  end

  // Sticky flag: only a window restart or reset clears it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign o_err = err_q;
endmodule

module svi_lane_checker #(
  parameter int               LANES    = 8,
  parameter logic [LANES-1:0] EXP_A    = 8'hFF,
  parameter logic [LANES-1:0] EXP_B    = 8'h00,
  parameter logic [LANES-1:0] EXP_C    = 8'hFF,
  parameter int               NSAMPLES = 16,
  parameter int               CNT_W    = 16,
  localparam int              SC_W     = $clog2(NSAMPLES + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [LANES-1:0] i_a,
  input  logic [LANES-1:0] i_b,
  input  logic [LANES-1:0] i_c,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [LANES-1:0] o_err_lanes,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [SC_W-1:0]  o_sample_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Stage-1 captured sample.
  typedef struct packed {
    logic [LANES-1:0] a;
    logic [LANES-1:0] b;
    logic [LANES-1:0] c;
  } smp_t;

  state_t           state_q, state_d;
  smp_t             s1_q, s1_d;
  logic             s1_vld_q, s1_vld_d;
  logic [SC_W-1:0]  sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             pass_q, pass_d;

  logic             enter_check;
  logic             accept;
  logic             last_accept;
  logic [LANES-1:0] lane_mm;
  logic [LANES-1:0] lane_hit;
  logic [LANES-1:0] err_lanes;

  // A restart is only honoured from IDLE or DONE; it clears the window.
  assign enter_check = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign accept      = (state_q == S_CHECK) && i_valid
                       && (sample_cnt_q < SC_W'(NSAMPLES));
  assign last_accept = accept && (sample_cnt_q == SC_W'(NSAMPLES - 1));

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: leave CHECK on the edge that takes the final sample so
  // DRAIN covers the one cycle the last sample spends in stage 2.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start)    state_d = S_CHECK;
      S_CHECK: if (last_accept) state_d = S_DRAIN;
      S_DRAIN:                 state_d = S_DONE;
      S_DONE:  if (i_start)    state_d = S_CHECK;
      default:                 state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    o_busy = (state_q == S_CHECK) || (state_q == S_DRAIN);
    o_done = (state_q == S_DONE);
  end

  // Stage 1 next state: capture accepted samples, count them.
  always_comb begin
    s1_d         = s1_q;
    s1_vld_d     = accept;
    sample_cnt_d = sample_cnt_q;
    if (enter_check) begin
      s1_vld_d     = 1'b0;
      sample_cnt_d = '0;
    end else if (accept) begin
      s1_d.a       = i_a;
      s1_d.b       = i_b;
      s1_d.c       = i_c;
      sample_cnt_d = sample_cnt_q + 1'b1;
    end
  end

  // Stage 1 registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_q         <= '0;
      s1_vld_q     <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      s1_q         <= s1_d;
      s1_vld_q     <= s1_vld_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // Stage 2: one compare/sticky-flag slice per lane.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    svi_lane_cmp #(
      .EXP_A_BIT (EXP_A[k]),
      .EXP_B_BIT (EXP_B[k]),
      .EXP_C_BIT (EXP_C[k])
    ) u_cmp (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (enter_check),
      .i_vld   (s1_vld_q),
      .i_a     (s1_q.a[k]),
      .i_b     (s1_q.b[k]),
      .i_c     (s1_q.c[k]),
      .o_mm    (lane_mm[k]),
      .o_err   (err_lanes[k])
    );
  end

  assign lane_hit = s1_vld_q ? lane_mm : '0;

  // Stage 2 count and pass verdict. The verdict is taken from the flags as
  // they will be after this edge so it is final on the first DONE cycle.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (enter_check)
      err_cnt_d = '0;
    else if ((|lane_hit) && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
    pass_d = (state_d == S_DONE) && !(|(err_lanes | lane_hit));
  end

  // Stage 2 registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err_cnt_q <= '0;
      pass_q    <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      pass_q    <= pass_d;
    end
  end

  assign o_pass       = pass_q;
  assign o_err_lanes  = err_lanes;
  assign o_err_cnt    = err_cnt_q;
  assign o_sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_svi_lane_checker.sv
// Directed bench for svi_lane_checker: table of full windows plus
// hand-written sequences for reset, gaps, saturation and restart cases.
module tb_svi_lane_checker;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, valid;
  logic [7:0] a, b, c;
  logic       busy, done, pass;
  logic [7:0] err_lanes;
  logic [15:0] err_cnt;
  logic [4:0] scnt;

  // Saturation instance: CNT_W=3, NSAMPLES=10.
  logic       s_start, s_valid;
  logic [7:0] s_a, s_b, s_c;
  logic       s_busy, s_done, s_pass;
  logic [7:0] s_err_lanes;
  logic [2:0] s_err_cnt;
  logic [3:0] s_scnt;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  svi_lane_checker dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid),
    .i_a(a), .i_b(b), .i_c(c),
    .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_err_lanes(err_lanes), .o_err_cnt(err_cnt), .o_sample_cnt(scnt)
  );

  svi_lane_checker #(.NSAMPLES(10), .CNT_W(3)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_valid(s_valid),
    .i_a(s_a), .i_b(s_b), .i_c(s_c),
    .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass),
    .o_err_lanes(s_err_lanes), .o_err_cnt(s_err_cnt), .o_sample_cnt(s_scnt)
  );

  typedef struct {
    logic [7:0] a, b, c;
    logic [7:0] exp_lanes;
    int         exp_cnt;
    logic       exp_pass;
  } win_t;

  win_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"},  32'(busy), 0);
    chk({tag, " done"},  32'(done), 0);
    chk({tag, " pass"},  32'(pass), 0);
    chk({tag, " lanes"}, 32'(err_lanes), 0);
    chk({tag, " cnt"},   32'(err_cnt), 0);
    chk({tag, " scnt"},  32'(scnt), 0);
  endtask

  // Start a window, push 16 back-to-back samples, wait (bounded) for done.
  task automatic run_window(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vc);
    int n;
    start = 1'b1; tick(); start = 1'b0;
    chk("entry busy",  32'(busy), 1);
    chk("entry lanes", 32'(err_lanes), 0);
    chk("entry cnt",   32'(err_cnt), 0);
    chk("entry scnt",  32'(scnt), 0);
    a = va; b = vb; c = vc;
    for (int i = 0; i < 16; i++) begin
      valid = 1'b1; tick();
    end
    valid = 1'b0; a = 8'hFF; b = 8'h00; c = 8'hFF;
    chk("drain state", 32'({busy, done}), 32'b10);
    n = 0;
    while (!done && n < 10) begin tick(); n++; end
    chk("done latency", 32'(n), 1);
  endtask

  initial begin
    tbl[0] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 0,  1'b1};
    tbl[1] = '{8'h7F, 8'h00, 8'hFF, 8'h80, 16, 1'b0};
    tbl[2] = '{8'hFF, 8'h01, 8'hFF, 8'h01, 16, 1'b0};
    tbl[3] = '{8'hFF, 8'h00, 8'hF0, 8'h0F, 16, 1'b0};
    tbl[4] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 16, 1'b0};
    tbl[5] = '{8'hFE, 8'h02, 8'hFF, 8'h03, 16, 1'b0};

    rst_n = 1'b0; start = 1'b0; valid = 1'b0;
    a = 8'hFF; b = 8'h00; c = 8'hFF;
    s_start = 1'b0; s_valid = 1'b0; s_a = 8'hFF; s_b = 8'h00; s_c = 8'hFF;

    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      valid = 1'($urandom); start = 1'($urandom);
      tick();
    end
    chk_zero("reset");
    rst_n = 1'b1; start = 1'b0; a = 8'hFF; b = 8'h00; c = 8'hFF;
    valid = 1'b1; tick(); tick(); tick(); valid = 1'b0;
    chk("idle valid scnt", 32'(scnt), 0);
    chk("idle valid busy", 32'(busy), 0);

    // Table of full windows, back to back (each restart from DONE).
    for (int i = 0; i < 6; i++) begin
      run_window(tbl[i].a, tbl[i].b, tbl[i].c);
      chk("win done",  32'(done), 1);
      chk("win busy",  32'(busy), 0);
      chk("win pass",  32'(pass), 32'(tbl[i].exp_pass));
      chk("win lanes", 32'(err_lanes), 32'(tbl[i].exp_lanes));
      chk("win cnt",   32'(err_cnt), 32'(tbl[i].exp_cnt));
      chk("win scnt",  32'(scnt), 16);
    end

    // Gapped window, lane 5 fault on samples 3 and 9, then a 17th valid.
    start = 1'b1; tick(); start = 1'b0;
    for (int j = 0; j < 32; j++) begin
      int idx;
      valid = (j % 2 == 0) || (j == 31);
      idx = j / 2 + 1;
      b = ((j % 2 == 0) && (idx == 3 || idx == 9)) ? 8'h20 : 8'h00;
      a = (j == 31) ? 8'h00 : 8'hFF;
      tick();
      if (j == 4) chk("gap cnt t+1", 32'(err_cnt), 0);
      if (j == 5) chk("gap cnt t+2", 32'(err_cnt), 1);
      if (j == 30) chk("gap drain", 32'({busy, done}), 32'b10);
    end
    valid = 1'b0; a = 8'hFF; b = 8'h00;
    chk("gap done",  32'(done), 1);
    chk("gap lanes", 32'(err_lanes), 32'h20);
    chk("gap cnt",   32'(err_cnt), 2);
    chk("gap pass",  32'(pass), 0);
    chk("gap scnt",  32'(scnt), 16);

    // Saturation on the CNT_W=3 / NSAMPLES=10 instance.
    s_start = 1'b1; tick(); s_start = 1'b0;
    s_a = 8'h00;
    for (int i = 0; i < 10; i++) begin s_valid = 1'b1; tick(); end
    s_valid = 1'b0; s_a = 8'hFF;
    tick();
    chk("sat done",  32'(s_done), 1);
    chk("sat cnt",   32'(s_err_cnt), 7);
    chk("sat lanes", 32'(s_err_lanes), 32'hFF);
    chk("sat scnt",  32'(s_scnt), 10);
    chk("sat pass",  32'(s_pass), 0);

    // Start during CHECK is ignored; reset mid-window discards everything.
    start = 1'b1; tick(); start = 1'b0;
    b = 8'h04;
    for (int i = 0; i < 5; i++) begin valid = 1'b1; tick(); end
    valid = 1'b0; start = 1'b1; tick(); start = 1'b0;
    chk("mid start scnt", 32'(scnt), 5);
    chk("mid start busy", 32'(busy), 1);
    for (int i = 6; i <= 8; i++) begin
      valid = 1'b1; tick();
      chk("mid scnt", 32'(scnt), 32'(i));
    end
    valid = 1'b0; b = 8'h00;
    chk("mid lanes", 32'(err_lanes), 32'h04);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk_zero("mid reset");
    run_window(8'hFF, 8'h00, 8'hFF);
    chk("post rst pass",  32'(pass), 1);
    chk("post rst lanes", 32'(err_lanes), 0);
    chk("post rst scnt",  32'(scnt), 16);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
